wb_irq_ctrl: RTL and testbench
==============================

# wb_irq_ctrl

Wishbone-attached interrupt controller that sits directly downstream of the timer and the other peripheral interrupt sources. It latches per-source interrupt requests, including the timer's `timer_irq_o`, into pending bits, masks them, and resolves a fixed priority. It drives a single registered interrupt line plus the winning source index toward the CPU. Software services it over the same classic-pipelined Wishbone slave style as the other BoxLambda peripherals.

## Interface
- `NumIrqs`, 16: number of interrupt sources, legal range 1..32.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset; synchronous release is supplied externally.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_we_i`  in  1  write enable.
- `wb_addr_i`  in  8  word address.
- `wb_data_i`  in  32  write data.
- `wb_sel_i`  in  4  byte enables.
- `wb_stall_o`  out  1  tied 0.
- `wb_ack_o`  out  1  access complete (mapped address).
- `wb_err_o`  out  1  access complete (unmapped address).
- `wb_data_o`  out  32  read data, valid while `wb_ack_o`=1, otherwise 0.
- `irq_src_i`  in  NumIrqs  raw source lines; bit 0 is the timer.
- `irq_o`  out  1  registered: any enabled source is pending.
- `irq_id_o`  out  5  registered: index of the highest-priority enabled pending source; 0 when `irq_o`=0.

## Operation
- Registers (word offsets):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 EDGE: read/write; 1 = rising-edge source, 0 = level source.
  - 3 ACTIVE: read-only; bit 31 = `irq_o`, bits 4:0 = `irq_id_o`.
  - 4 SWSET: write 1 to set pending; reads 0.
- Bits at or above NumIrqs read 0 and ignore writes.
- Writes honour `wb_sel_i` per byte. Writes to ACTIVE are ignored but still acked.
- Offsets 5..255 produce `wb_err_o` instead of ack, return read data 0, and have no side effects.
- Edge source: a rising edge of the conditioned input sets pending. Pending holds until W1C.
- Level source: pending is set on every cycle the conditioned input is high. A W1C while the input is still high is overridden on the same cycle.
- Simultaneous set (edge, level, or SWSET) and W1C on the same bit: set wins.
- Changing EDGE on a bit does not alter its current pending value.
- Priority: lowest index wins. Source 0 (timer) has the highest priority.
- PENDING bits latch regardless of ENABLE. ENABLE gates only `irq_o` and `irq_id_o`.

## Timing
- Reset values: all registers 0, edge-detect history 0; `irq_o`, `irq_id_o`, `wb_ack_o`, `wb_err_o` and `wb_data_o` all 0.
- Bus:
  - Request is `wb_cyc_i & wb_stb_i`.
  - Ack or err is asserted exactly one cycle after the request, for one cycle per request.
  - Back-to-back requests get back-to-back acks.
  - Register writes take effect at the clock edge that samples the request.
  - Read data reflects register state at that same edge.
- Interrupt path, without synchronizer:
  - Input change sampled at edge N updates pending at edge N.
  - `irq_o` and `irq_id_o` update at edge N+1.
- Interrupt path, with synchronizer: two edges later than above.
- W1C at edge N deasserts `irq_o` at edge N+1, provided nothing else is pending.
- Reset asserted mid-transaction: ack/err drop immediately (asynchronously). The in-flight access is discarded.

## Configuration
- `WB_IRQ_CTRL_SYNC_EN` defined: each `irq_src_i` bit passes through a two-flop synchronizer (reset to 0) before edge/level logic. Adds 2 cycles of latency.
- Not defined: inputs are used directly and are required to be synchronous to `clk_i`.

## Structure
- `wb_irq_ctrl_pkg`: register offset localparams (`IRQ_PENDING`=0 … `IRQ_SWSET`=4), `ACTIVE_VALID_BIT`=31, and the ID width of 5.
- Sub-module `irq_prio_enc`: combinational NumIrqs-bit lowest-index priority encoder producing `{valid, id[4:0]}`. The top level registers its outputs.

## Test plan
- Reset, then read offsets 0–4 -> all return 0; `irq_o`=0; each read acked exactly 1 cycle after the request.
- ENABLE=0x1, EDGE=0x1, pulse `irq_src_i[0]` for 1 cycle -> PENDING=0x1, `irq_o`=1 and `irq_id_o`=0 at the latency stated in Timing. Write 0x1 to PENDING -> `irq_o`=0 the next cycle.
- ENABLE=0xFFFF, EDGE=0, hold `irq_src_i[5]` and `irq_src_i[9]` high -> `irq_id_o`=5 and ACTIVE reads 0x80000005. Write 0x20 to PENDING while the input stays high -> PENDING still 0x220. Drop source 5, then W1C 0x20 -> `irq_id_o`=9.
- Edge source rising on the same cycle as a W1C of that bit -> bit remains 1.
- SWSET write 0x8 with ENABLE=0 -> PENDING=0x8, `irq_o`=0. Then ENABLE=0x8 -> `irq_o`=1 and `irq_id_o`=3.
- Access offset 7 -> `wb_err_o`=1, no ack, data 0. Write ENABLE=0xFFFF with `wb_sel_i`=0b0001 -> ENABLE=0x00FF. Assert `rst_ni` low mid-request -> ack and all outputs 0 immediately.

Source files
------------

// File: rtl/wb_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_irq_ctrl_pkg
// Shared definitions for the Wishbone interrupt controller: register word
// offsets, the ACTIVE register layout and a byte-enable expansion helper.
// -----------------------------------------------------------------------------
package wb_irq_ctrl_pkg;

  // Width of the interrupt index reported to the CPU (covers up to 32 sources).
  localparam int IRQ_ID_W = 5;

  // Register word offsets.
  localparam logic [7:0] IRQ_PENDING = 8'd0;
  localparam logic [7:0] IRQ_ENABLE  = 8'd1;
  localparam logic [7:0] IRQ_EDGE    = 8'd2;
  localparam logic [7:0] IRQ_ACTIVE  = 8'd3;
  localparam logic [7:0] IRQ_SWSET   = 8'd4;

  // ACTIVE register: bit 31 mirrors irq_o, the low bits hold irq_id_o.
  localparam int ACTIVE_VALID_BIT = 31;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index-wins priority encoder.
//   req   in  NumIrqs  request vector (already masked by the caller)
//   valid out 1        at least one request bit set
//   id    out 5        index of the lowest set bit, 0 when valid=0
// -----------------------------------------------------------------------------
module irq_prio_enc
  import wb_irq_ctrl_pkg::*;
#(
  parameter int NumIrqs = 16
) (
  input  logic [NumIrqs-1:0]  req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    valid = 1'b0;
    id    = '0;
    for (int i = NumIrqs - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// wb_irq_ctrl
// Wishbone (classic-pipelined) interrupt controller. Latches per-source
// requests into PENDING, masks with ENABLE and reports the lowest-index
// enabled pending source on a registered irq_o / irq_id_o pair.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   wb_cyc_i .. wb_sel_i    Wishbone slave request (8-bit word address)
//   wb_stall_o              always 0
//   wb_ack_o / wb_err_o     one-cycle response, mapped / unmapped offset
//   wb_data_o               read data while wb_ack_o=1, otherwise 0
//   irq_src_i               raw interrupt sources, bit 0 = timer
//   irq_o, irq_id_o         registered interrupt request and winning index
//
// Register map (word offsets): 0 PENDING (W1C), 1 ENABLE, 2 EDGE,
// 3 ACTIVE (RO), 4 SWSET (write-1-to-set, reads 0). Offsets 5..255 -> err.
//
// Build option: define WB_IRQ_CTRL_SYNC_EN to pass each source through a
// two-flop synchronizer (2 extra cycles of latency). Without it the sources
// must already be synchronous to clk_i.
// -----------------------------------------------------------------------------
module wb_irq_ctrl
  import wb_irq_ctrl_pkg::*;
#(
  parameter int NumIrqs = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [7:0]          wb_addr_i,
  input  logic [31:0]         wb_data_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_stall_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [31:0]         wb_data_o,
  input  logic [NumIrqs-1:0]  irq_src_i,
  output logic                irq_o,
  output logic [IRQ_ID_W-1:0] irq_id_o
);

  logic [NumIrqs-1:0]  pending;
  logic [NumIrqs-1:0]  enable;
  logic [NumIrqs-1:0]  edge_sel;
  logic [NumIrqs-1:0]  src_prev;
  logic [NumIrqs-1:0]  src_c;
  logic [NumIrqs-1:0]  set_bits;
  logic [NumIrqs-1:0]  clr_bits;
  logic [NumIrqs-1:0]  wr_bits;
  logic [NumIrqs-1:0]  byte_mask;
  logic [31:0]         wr_word;
  logic [31:0]         rd_data;
  logic                req;
  logic                mapped;
  logic                wr_pend;
  logic                wr_en;
  logic                wr_edge;
  logic                wr_swset;
  logic                prio_valid;
  logic [IRQ_ID_W-1:0] prio_id;
  logic                unused_bits;

  assign wb_stall_o = 1'b0;

  // ---------------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------------
`ifdef WB_IRQ_CTRL_SYNC_EN
  logic [NumIrqs-1:0] sync_q1;
  logic [NumIrqs-1:0] sync_q2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_c = sync_q2;
`else
  assign src_c = irq_src_i;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign req       = wb_cyc_i & wb_stb_i;
  assign mapped    = (wb_addr_i <= IRQ_SWSET);
  assign wr_word   = wb_data_i & sel_to_mask(wb_sel_i);
  assign wr_bits   = wr_word[NumIrqs-1:0];
  assign byte_mask = NumIrqs'(sel_to_mask(wb_sel_i));
  assign wr_pend   = req & wb_we_i & (wb_addr_i == IRQ_PENDING);
  assign wr_en     = req & wb_we_i & (wb_addr_i == IRQ_ENABLE);
  assign wr_edge   = req & wb_we_i & (wb_addr_i == IRQ_EDGE);
  assign wr_swset  = req & wb_we_i & (wb_addr_i == IRQ_SWSET);

  // Data bits above NumIrqs have no register behind them.
  assign unused_bits = ^wr_word;

  // Edge sources set on a rising edge, level sources on every high cycle,
  // software on SWSET. Sets are OR-ed in after the clear so a set always
  // beats a same-cycle W1C.
  assign set_bits = (edge_sel & src_c & ~src_prev)
                  | (~edge_sel & src_c)
                  | (wr_swset ? wr_bits : '0);
  assign clr_bits = wr_pend ? wr_bits : '0;

  // Read data reflects register state before the sampling edge.
  always_comb begin
    rd_data = '0;
    case (wb_addr_i)
      IRQ_PENDING: rd_data = 32'(pending);
      IRQ_ENABLE:  rd_data = 32'(enable);
      IRQ_EDGE:    rd_data = 32'(edge_sel);
      IRQ_ACTIVE: begin
        rd_data[ACTIVE_VALID_BIT] = irq_o;
        rd_data[IRQ_ID_W-1:0]     = irq_id_o;
      end
      default:     rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Priority resolution (registered below)
  // ---------------------------------------------------------------------------
  irq_prio_enc #(
    .NumIrqs (NumIrqs)
  ) u_prio_enc (
    .req   (pending & enable),
    .valid (prio_valid),
    .id    (prio_id)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      pending   <= '0;
      enable    <= '0;
      edge_sel  <= '0;
      src_prev  <= '0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      pending  <= (pending & ~clr_bits) | set_bits;
      src_prev <= src_c;
      if (wr_en) begin
        enable <= (enable & ~byte_mask) | wr_bits;
      end
      if (wr_edge) begin
        edge_sel <= (edge_sel & ~byte_mask) | wr_bits;
      end
      irq_o     <= prio_valid;
      irq_id_o  <= prio_id;
      wb_ack_o  <= req & mapped;
      wb_err_o  <= req & ~mapped;
      wb_data_o <= (req & mapped) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_irq_ctrl
// Self-checking bench for wb_irq_ctrl (NumIrqs = 16). A behavioural model
// tracks the register file per bit and predicts every output each cycle;
// directed sequences pin the model with hand-computed values, followed by a
// randomized bus/source phase. Honours WB_IRQ_CTRL_SYNC_EN for latency.
// -----------------------------------------------------------------------------
module tb_wb_irq_ctrl;

  localparam int N = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         wb_cyc_i = 1'b0;
  logic         wb_stb_i = 1'b0;
  logic         wb_we_i = 1'b0;
  logic [7:0]   wb_addr_i = '0;
  logic [31:0]  wb_data_i = '0;
  logic [3:0]   wb_sel_i = '0;
  logic         wb_stall_o;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic [31:0]  wb_data_o;
  logic [N-1:0] irq_src_i = '0;
  logic         irq_o;
  logic [4:0]   irq_id_o;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;

  wb_irq_ctrl #(.NumIrqs(N)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .wb_sel_i   (wb_sel_i),
    .wb_stall_o (wb_stall_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_data_o  (wb_data_o),
    .irq_src_i  (irq_src_i),
    .irq_o      (irq_o),
    .irq_id_o   (irq_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: per-bit register state, updated at each rising edge
  // from the inputs that edge samples; m_* outputs are what the DUT must show
  // after that edge.
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_pend, m_en, m_edge, m_prev, m_s1, m_s2;
  logic         m_irq, m_ack, m_err;
  logic [4:0]   m_id;
  logic [31:0]  m_data;

  always @(posedge clk_i or negedge rst_ni) begin : model
    logic [N-1:0] cond, bm, wd;
    logic         rq, s, c;
    int           best;
    if (!rst_ni) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_irq = 1'b0; m_id = '0; m_ack = 1'b0; m_err = 1'b0; m_data = '0;
    end else begin
`ifdef WB_IRQ_CTRL_SYNC_EN
      cond = m_s2;
`else
      cond = irq_src_i;
`endif
      rq = wb_cyc_i && wb_stb_i;
      // Bus response uses the state as it was before this edge.
      m_ack  = rq && (wb_addr_i < 8'd5);
      m_err  = rq && (wb_addr_i >= 8'd5);
      m_data = '0;
      if (m_ack) begin
        case (wb_addr_i)
          8'd0: m_data = {16'h0, m_pend};
          8'd1: m_data = {16'h0, m_en};
          8'd2: m_data = {16'h0, m_edge};
          8'd3: m_data = {m_irq, 26'h0, m_id};
          default: m_data = '0;
        endcase
      end
      for (int b = 0; b < 2; b++) bm[8*b +: 8] = wb_sel_i[b] ? 8'hFF : 8'h00;
      wd = wb_data_i[N-1:0] & bm;
      // Interrupt outputs: lowest enabled pending index before this edge.
      best = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) best = i;
      m_irq = (best >= 0);
      m_id  = (best >= 0) ? 5'(best) : 5'd0;
      // Pending update: set wins over clear.
      for (int i = 0; i < N; i++) begin
        s = (m_edge[i] ? (cond[i] && !m_prev[i]) : cond[i])
            || (rq && wb_we_i && wb_addr_i == 8'd4 && wd[i]);
        c = rq && wb_we_i && wb_addr_i == 8'd0 && wd[i];
        if (s) m_pend[i] = 1'b1;
        else if (c) m_pend[i] = 1'b0;
      end
      m_prev = cond;
      if (rq && wb_we_i && wb_addr_i == 8'd1) m_en   = (m_en & ~bm) | wd;
      if (rq && wb_we_i && wb_addr_i == 8'd2) m_edge = (m_edge & ~bm) | wd;
      m_s2 = m_s1;
      m_s1 = irq_src_i;
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("cyc_ack",   32'(wb_ack_o),   32'(m_ack));
      check("cyc_err",   32'(wb_err_o),   32'(m_err));
      check("cyc_data",  wb_data_o,       m_data);
      check("cyc_irq",   32'(irq_o),      32'(m_irq));
      check("cyc_id",    32'(irq_id_o),   32'(m_id));
      check("cyc_stall", 32'(wb_stall_o), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_data_i = d; wb_sel_i = s;
    @(negedge clk_i);
    rd = wb_data_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, 4'hF, v);
    check(name, v, exp);
  endtask

  initial begin
    // ---- reset ----
    cycles(3);
    check("rst_irq",  32'(irq_o),    32'd0);
    check("rst_id",   32'(irq_id_o), 32'd0);
    check("rst_ack",  32'(wb_ack_o), 32'd0);
    check("rst_data", wb_data_o,     32'd0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    for (int a = 0; a < 5; a++) rd_chk("rst_read", 8'(a), 32'h0);

    // ---- edge source on the timer ----
    wr(8'd1, 32'h1);
    wr(8'd2, 32'h1);
    @(negedge clk_i); irq_src_i[0] = 1'b1;
    @(negedge clk_i); irq_src_i[0] = 1'b0;
    cycles(4);
    rd_chk("edge_pend", 8'd0, 32'h1);
    check("edge_irq", 32'(irq_o),    32'd1);
    check("edge_id",  32'(irq_id_o), 32'd0);
    wr(8'd0, 32'h1);
    cycles(1);
    check("w1c_irq_low", 32'(irq_o), 32'd0);

    // ---- level sources 5 and 9 ----
    wr(8'd2, 32'h0);
    wr(8'd1, 32'hFFFF);
    irq_src_i[5] = 1'b1; irq_src_i[9] = 1'b1;
    cycles(4);
    check("lvl_id5", 32'(irq_id_o), 32'd5);
    rd_chk("lvl_active", 8'd3, 32'h8000_0005);
    wr(8'd0, 32'h20);
    rd_chk("lvl_w1c_override", 8'd0, 32'h220);
    irq_src_i[5] = 1'b0;
    cycles(4);
    wr(8'd0, 32'h20);
    cycles(2);
    check("lvl_id9", 32'(irq_id_o), 32'd9);
    irq_src_i[9] = 1'b0;
    cycles(4);
    wr(8'd0, 32'hFFFF);
    rd_chk("lvl_clear", 8'd0, 32'h0);

    // ---- edge rising on the same cycle as W1C of that bit ----
    wr(8'd2, 32'h4);
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_addr_i = 8'd0; wb_data_i = 32'h4; wb_sel_i = 4'hF;
    irq_src_i[2] = 1'b1;
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    cycles(3);
    rd_chk("edge_vs_w1c", 8'd0, 32'h4);
    irq_src_i[2] = 1'b0;
    cycles(3);
    wr(8'd0, 32'h4);
    rd_chk("edge_cleared", 8'd0, 32'h0);

    // ---- software set ----
    wr(8'd1, 32'h0);
    wr(8'd4, 32'h8);
    rd_chk("swset_pend", 8'd0, 32'h8);
    check("swset_irq_masked", 32'(irq_o), 32'd0);
    wr(8'd1, 32'h8);
    cycles(2);
    check("swset_irq", 32'(irq_o),    32'd1);
    check("swset_id",  32'(irq_id_o), 32'd3);
    rd_chk("swset_reads0", 8'd4, 32'h0);
    wr(8'd0, 32'h8);

    // ---- unmapped offset ----
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 8'd7;
    @(negedge clk_i);
    check("unmapped_err",  32'(wb_err_o), 32'd1);
    check("unmapped_ack",  32'(wb_ack_o), 32'd0);
    check("unmapped_data", wb_data_o,     32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    // ---- byte enables ----
    wr(8'd1, 32'h0);
    begin
      logic [31:0] dummy;
      bus(1'b1, 8'd1, 32'hFFFF, 4'b0001, dummy);
    end
    rd_chk("sel_enable", 8'd1, 32'h00FF);

    // ---- randomized phase ----
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk_i);
      wb_cyc_i  = ($urandom_range(0, 3) != 0);
      wb_stb_i  = ($urandom_range(0, 3) != 0);
      wb_we_i   = $urandom_range(0, 1) == 1;
      wb_addr_i = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wb_data_i = $urandom;
      wb_sel_i  = 4'($urandom);
      if ($urandom_range(0, 2) == 0) irq_src_i[$urandom_range(0, N - 1)] ^= 1'b1;
    end
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;

    // ---- reset asserted mid-request ----
    wr(8'd1, 32'hFFFF);
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 8'd1;
    @(posedge clk_i);
    #2;
    check("pre_rst_ack", 32'(wb_ack_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ack",  32'(wb_ack_o), 32'd0);
    check("mid_rst_err",  32'(wb_err_o), 32'd0);
    check("mid_rst_data", wb_data_o,     32'd0);
    check("mid_rst_irq",  32'(irq_o),    32'd0);
    check("mid_rst_id",   32'(irq_id_o), 32'd0);
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    irq_src_i = '0;
    cycles(2);
    rst_ni = 1'b1;
    rd_chk("post_rst_enable", 8'd1, 32'h0);
    cycles(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
